// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: stall-controller FSM encoding and opcode constants
// used by StallDetection, decode and the benches.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } pipe_state_e;

    localparam int unsigned OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline register sequencing from hazard and control-flow inputs, with
// halt/drain handshake, saturating performance counters and a stall watchdog.
module pipeline_stall_controller
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned MAX_STALL    = 8,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IDstall,
    input  logic             EXstall,
    input  logic             IDbranch_taken,
    input  logic             IDjump,
    input  logic             halt_req,
    output logic             PCwrite,
    output logic             IFIDwrite,
    output logic             IFIDflush,
    output logic             IDEXwrite,
    output logic             IDEXflush,
    output logic             EXMEMflush,
    output logic             halt_ack,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] cyc_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    pipe_state_e        state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [STALL_W-1:0] consec_q, consec_d;
    logic               halt_ack_q, halt_ack_d;
    logic               timeout_q, timeout_d;

    logic stall_any;
    logic stall_hon;
    logic cyc_en;
    logic flush_en;

    assign stall_any = EXstall | IDstall;
    assign stall_hon = (state_q != ST_HALTED) && stall_any;
    assign cyc_en    = (state_q == ST_RUN);
    assign flush_en  = (state_q == ST_RUN) && !stall_any && (IDbranch_taken | IDjump);

    // Control outputs and next state; EX hazard outranks ID hazard outranks control flow.
    always_comb begin
        PCwrite    = 1'b0;
        IFIDwrite  = 1'b0;
        IFIDflush  = 1'b0;
        IDEXwrite  = 1'b0;
        IDEXflush  = 1'b0;
        EXMEMflush = 1'b0;
        state_d    = state_q;
        drain_d    = drain_q;

        if (state_q != ST_HALTED) begin
            if (EXstall) begin
                EXMEMflush = 1'b1;
            end else if (IDstall) begin
                IDEXwrite = 1'b1;
                IDEXflush = 1'b1;
            end else if (state_q == ST_DRAIN) begin
                IFIDwrite = 1'b1;
                IFIDflush = 1'b1;
                IDEXwrite = 1'b1;
            end else begin
                PCwrite   = 1'b1;
                IFIDwrite = 1'b1;
                IDEXwrite = 1'b1;
                IFIDflush = IDbranch_taken | IDjump;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (halt_req && !stall_any) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                    drain_d = '0;
                end else if (!stall_any) begin
                    if (drain_q + DRAIN_W'(1) == DRAIN_W'(DRAIN_CYCLES)) begin
                        state_d = ST_HALTED;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q + DRAIN_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                drain_d = '0;
            end
        endcase
    end

    // Watchdog: consecutive honoured stalls, sticky flag one edge after reaching the limit.
    always_comb begin
        consec_d   = '0;
        timeout_d  = timeout_q | (consec_q == STALL_W'(MAX_STALL));
        halt_ack_d = (state_d == ST_HALTED);
        if (stall_hon) begin
            consec_d = (consec_q == STALL_W'(MAX_STALL)) ? consec_q : consec_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            drain_q    <= '0;
            consec_q   <= '0;
            halt_ack_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            consec_q   <= consec_d;
            halt_ack_q <= halt_ack_d;
            timeout_q  <= timeout_d;
        end
    end

    assign halt_ack      = halt_ack_q;
    assign stall_timeout = timeout_q;

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (cyc_en),
        .clr   (1'b0),
        .cnt   (cyc_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_hon),
        .clr   (1'b0),
        .cnt   (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (flush_en),
        .clr   (1'b0),
        .cnt   (flush_count)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with 4-bit counters so saturation
// is reachable; expected values are hand-derived per step.
module tb_pipeline_stall_controller;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             IDstall;
    logic             EXstall;
    logic             IDbranch_taken;
    logic             IDjump;
    logic             halt_req;
    logic             PCwrite;
    logic             IFIDwrite;
    logic             IFIDflush;
    logic             IDEXwrite;
    logic             IDEXflush;
    logic             EXMEMflush;
    logic             halt_ack;
    logic             stall_timeout;
    logic [CNT_W-1:0] cyc_count;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    int n_cmp;
    int n_mis;

    pipeline_stall_controller #(
        .CNT_W        (CNT_W),
        .MAX_STALL    (8),
        .DRAIN_CYCLES (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .IDstall        (IDstall),
        .EXstall        (EXstall),
        .IDbranch_taken (IDbranch_taken),
        .IDjump         (IDjump),
        .halt_req       (halt_req),
        .PCwrite        (PCwrite),
        .IFIDwrite      (IFIDwrite),
        .IFIDflush      (IFIDflush),
        .IDEXwrite      (IDEXwrite),
        .IDEXflush      (IDEXflush),
        .EXMEMflush     (EXMEMflush),
        .halt_ack       (halt_ack),
        .stall_timeout  (stall_timeout),
        .cyc_count      (cyc_count),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        reset = 1'b0;
        IDstall = 1'b0;
        EXstall = 1'b0;
        IDbranch_taken = 1'b0;
        IDjump = 1'b0;
        halt_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_halt_ack", 32'(halt_ack), 32'd0);
        chk("rst_timeout", 32'(stall_timeout), 32'd0);
        chk("rst_cyc", 32'(cyc_count), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);
        chk("rst_flush", 32'(flush_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle RUN
        chk("idle_pcw", 32'(PCwrite), 32'd1);
        chk("idle_ifidw", 32'(IFIDwrite), 32'd1);
        chk("idle_idexw", 32'(IDEXwrite), 32'd1);
        chk("idle_flushes", 32'({IFIDflush, IDEXflush, EXMEMflush}), 32'd0);
        repeat (5) cyc();
        chk("idle_cyc5", 32'(cyc_count), 32'd5);
        chk("idle_stall0", 32'(stall_count), 32'd0);

        // EXstall outranks IDstall and branch
        EXstall = 1'b1; IDstall = 1'b1; IDbranch_taken = 1'b1;
        #1;
        chk("ex_pcw", 32'(PCwrite), 32'd0);
        chk("ex_ifidw", 32'(IFIDwrite), 32'd0);
        chk("ex_idexw", 32'(IDEXwrite), 32'd0);
        chk("ex_exmemflush", 32'(EXMEMflush), 32'd1);
        chk("ex_ifidflush", 32'(IFIDflush), 32'd0);
        cyc();
        EXstall = 1'b0; IDstall = 1'b0; IDbranch_taken = 1'b0;
        chk("ex_stall_cnt", 32'(stall_count), 32'd1);
        chk("ex_flush_cnt", 32'(flush_count), 32'd0);
        chk("ex_cyc_cnt", 32'(cyc_count), 32'd6);

        // IDstall then taken branch
        IDstall = 1'b1;
        #1;
        chk("id_idexflush", 32'(IDEXflush), 32'd1);
        chk("id_pcw", 32'(PCwrite), 32'd0);
        chk("id_idexw", 32'(IDEXwrite), 32'd1);
        cyc();
        IDstall = 1'b0; IDbranch_taken = 1'b1;
        #1;
        chk("br_ifidflush", 32'(IFIDflush), 32'd1);
        chk("br_pcw", 32'(PCwrite), 32'd1);
        cyc();
        IDbranch_taken = 1'b0;
        chk("br_flush_cnt", 32'(flush_count), 32'd1);
        chk("br_stall_cnt", 32'(stall_count), 32'd2);

        // Jump also counts as a control-flow flush
        IDjump = 1'b1;
        #1;
        chk("j_ifidflush", 32'(IFIDflush), 32'd1);
        cyc();
        IDjump = 1'b0;
        chk("j_flush_cnt", 32'(flush_count), 32'd2);

        // Watchdog: 9 consecutive ID stalls
        IDstall = 1'b1;
        repeat (7) cyc();
        chk("wd_before", 32'(stall_timeout), 32'd0);
        repeat (2) cyc();
        chk("wd_set", 32'(stall_timeout), 32'd1);
        chk("wd_pcw_unaltered", 32'(PCwrite), 32'd0);
        IDstall = 1'b0;
        cyc();
        chk("wd_sticky", 32'(stall_timeout), 32'd1);
        chk("wd_stall_cnt", 32'(stall_count), 32'd11);
        chk("cyc_saturated", 32'(cyc_count), 32'd15);

        // Halt with clean drain
        halt_req = 1'b1;
        #1;
        chk("halt_req_run_pcw", 32'(PCwrite), 32'd1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("drain_pcw", 32'(PCwrite), 32'd0);
            chk("drain_ifidflush", 32'(IFIDflush), 32'd1);
            chk("drain_ifidw", 32'(IFIDwrite), 32'd1);
            chk("drain_ack", 32'(halt_ack), 32'd0);
            cyc();
        end
        chk("halted_ack", 32'(halt_ack), 32'd1);
        chk("halted_ctl", 32'({PCwrite, IFIDwrite, IDEXwrite, IFIDflush, IDEXflush, EXMEMflush}), 32'd0);
        cyc();
        chk("halted_stall_frozen", 32'(stall_count), 32'd11);
        chk("halted_flush_frozen", 32'(flush_count), 32'd2);
        halt_req = 1'b0;
        #1;
        chk("unhalt_ack_held", 32'(halt_ack), 32'd1);
        cyc();
        chk("unhalt_ack", 32'(halt_ack), 32'd0);
        chk("unhalt_pcw", 32'(PCwrite), 32'd1);

        // Halt with one EX stall inside DRAIN
        halt_req = 1'b1;
        cyc();
        cyc();
        EXstall = 1'b1;
        #1;
        chk("drain_ex_exmemflush", 32'(EXMEMflush), 32'd1);
        chk("drain_ex_ifidflush", 32'(IFIDflush), 32'd0);
        chk("drain_ex_idexw", 32'(IDEXwrite), 32'd0);
        cyc();
        EXstall = 1'b0;
        cyc();
        cyc();
        chk("drain_ex_not_yet", 32'(halt_ack), 32'd0);
        chk("drain_ex_still_flush", 32'(IFIDflush), 32'd1);
        cyc();
        chk("drain_ex_halted", 32'(halt_ack), 32'd1);
        chk("drain_ex_stall_cnt", 32'(stall_count), 32'd12);

        // halt_req drop mid-DRAIN returns to RUN
        halt_req = 1'b0;
        cyc();
        halt_req = 1'b1;
        cyc();
        cyc();
        halt_req = 1'b0;
        cyc();
        chk("drain_abort_pcw", 32'(PCwrite), 32'd1);
        chk("drain_abort_ack", 32'(halt_ack), 32'd0);

        // stall_count saturation
        IDstall = 1'b1;
        repeat (20) cyc();
        IDstall = 1'b0;
        chk("stall_saturated", 32'(stall_count), 32'd15);

        // Async reset while HALTED
        halt_req = 1'b1;
        repeat (5) cyc();
        chk("pre_rst_ack", 32'(halt_ack), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("arst_ack", 32'(halt_ack), 32'd0);
        chk("arst_timeout", 32'(stall_timeout), 32'd0);
        chk("arst_counts", 32'({cyc_count, stall_count, flush_count}), 32'd0);
        chk("arst_pcw", 32'(PCwrite), 32'd1);
        reset = 1'b0;
        halt_req = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Sequences the 5-stage pipelined CPU's pipeline registers from the hazard outputs of StallDetection (IDstall, EXstall) and ID-stage control-flow resolution (branch taken, jump).
- Generates per-register write enables and bubble/flush controls.
- Provides a halt/drain handshake, saturating performance counters and a stall watchdog.
- Sits beside StallDetection in the CPU top; drives PC, IF/ID, ID/EX and EX/MEM registers.

Parameters:
- CNT_W, 16, width of the saturating performance counters.
- MAX_STALL, 8, consecutive stall cycles tolerated before timeout is flagged.
- DRAIN_CYCLES, 4, bubble cycles needed to empty ID..WB after fetch stops.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- IDstall  in  1  ID-stage hazard from StallDetection
- EXstall  in  1  EX-stage load-use hazard from StallDetection
- IDbranch_taken  in  1  BEQ/BNE resolved taken in ID
- IDjump  in  1  J decoded in ID
- halt_req  in  1  level request to stop and drain the pipeline
- PCwrite  out  1  PC register enable
- IFIDwrite  out  1  IF/ID enable
- IFIDflush  out  1  IF/ID loads NOP
- IDEXwrite  out  1  ID/EX enable
- IDEXflush  out  1  ID/EX loads bubble
- EXMEMflush  out  1  EX/MEM loads bubble
- halt_ack  out  1  pipeline empty and halted
- stall_timeout  out  1  sticky watchdog flag
- cyc_count  out  CNT_W  RUN-state cycles
- stall_count  out  CNT_W  stall cycles
- flush_count  out  CNT_W  control-flow flush cycles

Behaviour:
- The already-decided interface: one clock; reset is asynchronous and active-high.
- States: RUN, DRAIN, HALTED. Reset puts the FSM in RUN.
- Reset values: all counters 0, drain counter 0, stall_timeout 0, halt_ack 0.
- Control outputs are combinational from state and inputs, so they are valid in the same cycle. All other outputs are registered.
- RUN priority, highest first (exactly one case applies per cycle):
  - EXstall: PCwrite=0, IFIDwrite=0, IDEXwrite=0, EXMEMflush=1. IDstall, branch and jump are ignored this cycle.
  - IDstall: PCwrite=0, IFIDwrite=0, IDEXwrite=1, IDEXflush=1. Branch/jump is ignored; the branch re-resolves after the stall.
  - IDbranch_taken or IDjump: PCwrite=1, IFIDwrite=1, IFIDflush=1.
  - Otherwise: PCwrite=IFIDwrite=IDEXwrite=1, all flushes 0.
- Counters (all saturate at 2^CNT_W-1 and never wrap):
  - cyc_count increments each RUN cycle.
  - stall_count increments each cycle where EXstall or IDstall is honoured.
  - flush_count increments each cycle where IFIDflush=1 due to branch/jump.
- Watchdog:
  - A consecutive-stall counter increments on each honoured stall and clears on any non-stall cycle.
  - When it reaches MAX_STALL, stall_timeout sets on the next edge and stays set until reset.
  - Stall control outputs are not altered by the timeout.
- RUN to DRAIN: halt_req=1 sampled at a clock edge while no stall is active.
  - If a stall is active, the transition waits until the stall clears.
  - A taken branch/jump in that same cycle still completes its flush.
- DRAIN:
  - PCwrite=0, IFIDwrite=1, IFIDflush=1 (NOPs feed the pipe); IDEXwrite=1; EXstall/IDstall are still honoured as in RUN.
  - The drain counter counts non-stalled cycles.
  - After DRAIN_CYCLES non-stalled cycles, go to HALTED.
  - halt_req deasserting during DRAIN returns to RUN next cycle and clears the drain counter.
- HALTED:
  - PCwrite=0, IFIDwrite=0, IDEXwrite=0, all flushes 0; halt_ack=1 (registered, asserted on entry).
  - halt_req=0 returns to RUN next cycle; halt_ack drops on the same edge.
- Counters freeze in HALTED; cyc_count also freezes in DRAIN.
- Reset asserted mid-DRAIN or mid-HALTED returns to RUN immediately and clears all registered state.

Decomposition:
- Shared package cpu_pipe_pkg:
  - FSM state encoding (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2).
  - Opcode constants LW, SW, RTYPE, BEQ, BNE, J, ADDI, SLTI, so StallDetection, decode and benches share them.
- One natural sub-module, sat_counter (parameterised width; enable, clear; saturates). Instantiate it three times for the performance counters.

Test Plan:
- Reset, then 5 idle cycles → PCwrite=IFIDwrite=IDEXwrite=1, flushes 0, cyc_count=5, stall_count=0.
- EXstall=1 and IDstall=1 with IDbranch_taken=1 for 1 cycle → PCwrite=0, IDEXwrite=0, EXMEMflush=1, IFIDflush=0; stall_count=1, flush_count=0.
- IDstall=1 for 1 cycle, then IDbranch_taken=1 → first cycle IDEXflush=1, PCwrite=0; second cycle IFIDflush=1; flush_count=1.
- IDstall held for 9 cycles with MAX_STALL=8 → stall_timeout=1 after the 8th stall cycle and stays 1 after IDstall drops.
- halt_req=1 with no hazards → 4 DRAIN cycles with PCwrite=0 and IFIDflush=1, then halt_ack=1. Drop halt_req → RUN and halt_ack=0 next cycle. Repeat with EXstall pulsed in DRAIN → HALTED arrives 1 cycle later.
- Force stall_count near max (CNT_W=4, 20 stall cycles) → stall_count holds at 15. Assert reset during HALTED → all outputs return to reset values asynchronously.
